bias_add_stage: RTL



---
 rtl/bias_add_stage_if.sv | 55 +++++
 rtl/bias_add_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bias_add_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : bias_add_stage_if
// Purpose  : Bundles the bias-stage control, bias FIFO read port, accumulator
//            input stream and output stream into one interface.
// Ports    : none (signal bundle only)
//            start/num_bias/beats_per_bias/shift/relu_en - layer configuration
//            fifo_rden/fifo_dout/fifo_empty              - bias FIFO read port
//            acc_valid/acc_ready/acc_data                - accumulator stream
//            out_valid/out_ready/out_data                - result stream
//            busy/done                                   - layer status
//            slave modport  : the bias_add_stage block
//            master modport : the environment that drives it
// Revision : 1.0 - initial release
// ============================================================================
interface bias_add_stage_if #(
    parameter int LANES  = 5,
    parameter int BIAS_W = 8,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 8
);
    logic                      start;
    logic [7:0]                num_bias;
    logic [7:0]                beats_per_bias;
    logic [3:0]                shift;
    logic                      relu_en;
    logic                      fifo_rden;
    logic [LANES*BIAS_W-1:0]   fifo_dout;
    logic                      fifo_empty;
    logic                      acc_valid;
    logic                      acc_ready;
    logic [LANES*ACC_W-1:0]    acc_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*OUT_W-1:0]    out_data;
    logic                      busy;
    logic                      done;

    modport slave (
        input  start, num_bias, beats_per_bias, shift, relu_en,
        input  fifo_dout, fifo_empty,
        input  acc_valid, acc_data,
        input  out_ready,
        output fifo_rden, acc_ready, out_valid, out_data, busy, done
    );

    modport master (
        output start, num_bias, beats_per_bias, shift, relu_en,
        output fifo_dout, fifo_empty,
        output acc_valid, acc_data,
        output out_ready,
        input  fifo_rden, acc_ready, out_valid, out_data, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/bias_add_stage.sv
`default_nettype none
// ============================================================================
// Module   : bias_add_stage
// Purpose  : Post-accumulation stage. Pulls one bias word per group of
//            accumulator beats from the bias FIFO, splits it into LANES signed
//            biases and per lane computes sat(relu((acc + bias) >>> shift)).
//            Results leave on a valid/ready stream with a 1-cycle latency.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset
//            bus  - bias_add_stage_if.slave (config, FIFO read port,
//                   accumulator input stream, output stream, busy/done)
// Revision : 1.0 - initial release
// ============================================================================
module bias_add_stage #(
    parameter int LANES  = 5,
    parameter int BIAS_W = 8,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    bias_add_stage_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic signed [ACC_W:0] c_sat_max = (ACC_W+1)'((2**(OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] c_sat_min = (ACC_W+1)'(-(2**(OUT_W-1)));

    state_t                    r_state;
    logic [7:0]                r_num_bias;
    logic [7:0]                r_beats;
    logic [3:0]                r_shift;
    logic                      r_relu;
    logic [7:0]                r_bias_cnt;
    logic [7:0]                r_beat_cnt;
    logic [LANES*BIAS_W-1:0]   r_bias;
    logic                      r_out_valid;
    logic [LANES*OUT_W-1:0]    r_out_data;
    logic                      r_busy;
    logic                      r_done;

    logic                      w_acc_ready;
    logic                      w_fire;
    logic [LANES*OUT_W-1:0]    w_beat;

    // The read strobe is decoded from the state so the FIFO word arrives
    // exactly in LOAD, and it can never be raised against an empty FIFO.
    assign bus.fifo_rden = (r_state == S_FETCH) && !bus.fifo_empty;

    // A new beat is taken whenever the output register is free or being
    // drained in the same cycle.
    assign w_acc_ready   = (r_state == S_RUN) && (!r_out_valid || bus.out_ready);
    assign w_fire        = w_acc_ready && bus.acc_valid;

    assign bus.acc_ready = w_acc_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

    // ------------------------------------------------------------------
    // Per-lane datapath: widen by one bit so acc + bias cannot overflow,
    // shift arithmetically, clamp negatives under ReLU, then saturate.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [ACC_W-1:0]         w_acc;
            logic [BIAS_W-1:0]        w_bias;
            logic signed [ACC_W:0]    w_sum;
            logic signed [ACC_W:0]    w_shr;
            logic signed [ACC_W:0]    w_act;

            assign w_acc  = bus.acc_data[i*ACC_W +: ACC_W];
            assign w_bias = r_bias[i*BIAS_W +: BIAS_W];
            assign w_sum  = $signed({w_acc[ACC_W-1], w_acc})
                          + $signed({{(ACC_W+1-BIAS_W){w_bias[BIAS_W-1]}}, w_bias});
            assign w_shr  = w_sum >>> r_shift;
            assign w_act  = (r_relu && w_shr[ACC_W]) ? '0 : w_shr;

            always_comb begin
                w_beat[i*OUT_W +: OUT_W] = w_act[OUT_W-1:0];
                if (w_act > c_sat_max) begin
                    w_beat[i*OUT_W +: OUT_W] = c_sat_max[OUT_W-1:0];
                end else if (w_act < c_sat_min) begin
                    w_beat[i*OUT_W +: OUT_W] = c_sat_min[OUT_W-1:0];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM plus output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_num_bias  <= '0;
            r_beats     <= '0;
            r_shift     <= '0;
            r_relu      <= 1'b0;
            r_bias_cnt  <= '0;
            r_beat_cnt  <= '0;
            r_bias      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // A fire reloads the register even while the previous beat is
            // handshaking, keeping throughput at one beat per cycle.
            if (w_fire) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_beat;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_num_bias <= bus.num_bias;
                        r_beats    <= (bus.beats_per_bias == 8'd0) ? 8'd1 : bus.beats_per_bias;
                        r_shift    <= bus.shift;
                        r_relu     <= bus.relu_en;
                        r_bias_cnt <= '0;
                        r_beat_cnt <= '0;
                        if (bus.num_bias == 8'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (!bus.fifo_empty) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_bias  <= bus.fifo_dout;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_fire) begin
                        if (r_beat_cnt == r_beats - 8'd1) begin
                            r_beat_cnt <= '0;
                            r_bias_cnt <= r_bias_cnt + 8'd1;
                            // Leaving for DRAIN here guarantees no read past
                            // the last bias word of the layer.
                            if (r_bias_cnt == r_num_bias - 8'd1) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_state <= S_FETCH;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!r_out_valid || bus.out_ready) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
